// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if
// Bundles the requester-side handshake and the FIFO write-port signals of the
// round-robin write arbiter.
//   req        n_req        per-requester valid
//   req_data   n_req*width  packed beat data, requester i owns [i*width +: width]
//   ack        n_req        one-hot accept strobe back to the requesters
//   fifo_wdata width        to FIFO wdata
//   fifo_winc  1            to FIFO winc
//   fifo_wfull 1            from FIFO wfull (registered in the write domain)
//   gnt_id     idw          current owner index
//   busy       1            high while a burst is granted
// Modports: master = the arbiter, slave = requesters plus FIFO.
interface fifo_write_arbiter_if #(
  parameter int n_req = 4,
  parameter int width = 8,
  parameter int idw   = $clog2(n_req)
);
  logic [n_req-1:0]       req;
  logic [n_req*width-1:0] req_data;
  logic [n_req-1:0]       ack;
  logic [width-1:0]       fifo_wdata;
  logic                   fifo_winc;
  logic                   fifo_wfull;
  logic [idw-1:0]         gnt_id;
  logic                   busy;

  modport master (
    input  req, req_data, fifo_wfull,
    output ack, fifo_wdata, fifo_winc, gnt_id, busy
  );

  modport slave (
    output req, req_data, fifo_wfull,
    input  ack, fifo_wdata, fifo_winc, gnt_id, busy
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
// Round-robin arbiter sharing the single write port of the dual-clock FIFO
// among n_req requesters. Lives in the FIFO write-clock domain. An owner keeps
// the grant for up to max_burst beats, or until it drops its request; a full
// FIFO stalls the burst without ending it. Owner changes happen without a
// bubble; only leaving IDLE costs one arbitration cycle.
// Ports:
//   clk  write-domain clock (same net as the FIFO write clock)
//   rst  asynchronous, active-high reset
//   bus  fifo_write_arbiter_if.master (requester handshake + FIFO write port)
module fifo_write_arbiter #(
  parameter int n_req     = 4,
  parameter int width     = 8,
  parameter int max_burst = 4,
  parameter int idw       = $clog2(n_req)
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_write_arbiter_if.master  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [7:0]     last_beat = 8'(max_burst - 1);
  localparam logic [idw-1:0] last_rst  = idw'(n_req - 1);

  state_t         state, state_nx;
  logic [idw-1:0] owner, owner_nx;
  logic [idw-1:0] last, last_nx;
  logic [7:0]     beat_cnt, cnt_nx;

  logic [n_req-1:0] ack_v;
  logic             winc_v;
  logic             busy_v;
  logic             beat;
  logic             burst_end;

  // First requester found searching upward from prev+1 with wrap-around.
  // The wrap is done by subtraction so non-power-of-two n_req needs no divider.
  function automatic logic [idw-1:0] rr_pick(input logic [n_req-1:0] r,
                                             input logic [idw-1:0]   prev);
    logic [idw-1:0] sel;
    logic           hit;
    int             idx;
    sel = '0;
    hit = 1'b0;
    for (int k = 1; k <= n_req; k++) begin
      idx = int'(prev) + k;
      if (idx >= n_req) idx = idx - n_req;
      if (!hit && r[idx]) begin
        sel = idw'(idx);
        hit = 1'b1;
      end
    end
    return sel;
  endfunction

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_nx  = state;
    owner_nx  = owner;
    last_nx   = last;
    cnt_nx    = beat_cnt;
    ack_v     = '0;
    winc_v    = 1'b0;
    busy_v    = 1'b0;
    beat      = 1'b0;
    burst_end = 1'b0;

    case (state)
      IDLE: begin
        if (|bus.req) begin
          owner_nx = rr_pick(bus.req, last);
          cnt_nx   = '0;
          state_nx = BURST;
        end
      end

      BURST: begin
        busy_v = 1'b1;
        // Gating with wfull keeps winc identical to what the FIFO accepts,
        // so an ack always corresponds to a stored word.
        beat         = bus.req[owner] & ~bus.fifo_wfull;
        winc_v       = beat;
        ack_v[owner] = beat;

        if (beat) begin
          if (beat_cnt == last_beat) burst_end = 1'b1;
          else                       cnt_nx    = beat_cnt + 8'd1;
        end else if (!bus.req[owner]) begin
          // Voluntary release; a full stall with req held does not land here.
          burst_end = 1'b1;
        end

        if (burst_end) begin
          last_nx = owner;
          cnt_nx  = '0;
          // Hand over in the same cycle (no bubble); the current owner is
          // searched last, so it only regains the grant if it is alone.
          if (|bus.req) owner_nx = rr_pick(bus.req, owner);
          else          state_nx = IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      last     <= last_rst;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      last     <= last_nx;
      beat_cnt <= cnt_nx;
    end
  end

  // Outputs decode from the async-reset state, so asserting rst removes
  // winc/ack/busy immediately, mid-cycle.
  assign bus.ack        = ack_v;
  assign bus.fifo_winc  = winc_v;
  assign bus.busy       = busy_v;
  assign bus.gnt_id     = owner;
  assign bus.fifo_wdata = bus.req_data[int'(owner)*width +: width];

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter
// Directed scenarios for the round-robin FIFO write arbiter. Each requester is
// a small source model: it presents base+count while it has beats left and
// advances only on ack. Written words are checked against an expected-order
// queue filled by each scenario; per-cycle grant/strobe state is checked inline.
module tb_fifo_write_arbiter;
  localparam int n_req     = 4;
  localparam int width     = 8;
  localparam int max_burst = 4;
  localparam int idw       = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.n_req(n_req), .width(width), .idw(idw)) bus();

  fifo_write_arbiter #(
    .n_req(n_req), .width(width), .max_burst(max_burst), .idw(idw)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [9:0] exp_q[$];          // {owner, data} in the order the FIFO must see

  int               src_base[n_req];
  int               src_left[n_req];   // -1 = endless source
  int               src_cnt [n_req];
  logic [n_req-1:0] en;
  logic             full_drv;
  logic [n_req-1:0] ack_seen;

  function automatic logic [7:0] st();
    return {bus.busy, bus.fifo_winc, bus.ack, bus.gnt_id};
  endfunction

  function automatic logic [7:0] beat_st(int g);
    return {1'b1, 1'b1, 4'(1 << g), 2'(g)};
  endfunction

  function automatic logic [7:0] stall_st(int g);
    return {1'b1, 1'b0, 4'b0000, 2'(g)};
  endfunction

  task automatic push_exp(int g, int d);
    exp_q.push_back({2'(g), 8'(d)});
  endtask

  task automatic drive();
    logic [n_req-1:0]       r;
    logic [n_req*width-1:0] d;
    for (int i = 0; i < n_req; i++) begin
      r[i]                 = en[i] && (src_left[i] != 0);
      d[i*width +: width]  = 8'(src_base[i] + src_cnt[i]);
    end
    bus.req        = r;
    bus.req_data   = d;
    bus.fifo_wfull = full_drv;
  endtask

  // Advance the source models by the acks seen in the cycle just ended.
  task automatic apply();
    for (int i = 0; i < n_req; i++) begin
      if (ack_seen[i]) begin
        src_cnt[i]++;
        if (src_left[i] > 0) src_left[i]--;
      end
    end
    ack_seen = '0;
    drive();
  endtask

  // Ends 2 time units after the rising edge with new inputs settled.
  task automatic cycle();
    @(posedge clk);
    #1;
    apply();
    #1;
  endtask

  task automatic set_src(int i, int base, int left);
    src_base[i] = base;
    src_left[i] = left;
    src_cnt[i]  = 0;
    en[i]       = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = '0;
    for (int i = 0; i < n_req; i++) begin
      src_left[i] = 0;
      src_cnt[i]  = 0;
    end
    full_drv = 1'b0;
    ack_seen = '0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive();
    #1;
  endtask

  // Scoreboard and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [9:0] e;
    ack_seen = bus.ack;
    n_chk++;
    if (bus.ack !== (bus.fifo_winc ? 4'(1 << bus.gnt_id) : 4'b0000)) begin
      n_fail++;
      $display("FAIL ack_onehot: ack=%b winc=%b gnt=%0d", bus.ack, bus.fifo_winc, bus.gnt_id);
    end
    n_chk++;
    if (bus.fifo_winc === 1'b1 && bus.fifo_wfull === 1'b1) begin
      n_fail++;
      $display("FAIL winc_while_full: winc=1 with wfull=1, required winc=0");
    end
    if (bus.fifo_winc === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: gnt=%0d data=%h, required no write", bus.gnt_id, bus.fifo_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({bus.gnt_id, bus.fifo_wdata} !== e) begin
          n_fail++;
          $display("FAIL write_data: got owner %0d data %h, required owner %0d data %h",
                   bus.gnt_id, bus.fifo_wdata, e[9:8], e[7:0]);
        end
      end
    end
  end

  task automatic test_reset();
    logic [7:0] obs;
    rst = 1'b1;
    full_drv = 1'b0;
    ack_seen = '0;
    en = '0;
    for (int i = 0; i < n_req; i++) set_src(i, 8'hA5 + i, -1);
    drive();
    repeat (2) cycle();
    obs = st();
    n_chk++;
    if (obs !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required %b", obs, 8'b0);
    end
    n_chk++;
    if (bus.fifo_wdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL reset_wdata: got %h required %h", bus.fifo_wdata, 8'hA5);
    end
    do_reset();
  endtask

  task automatic test_single();
    logic [7:0] obs;
    do_reset();
    set_src(0, 'h11, 6);
    for (int d = 0; d < 6; d++) push_exp(0, 'h11 + d);
    drive();
    #1;
    obs = st();
    n_chk++;
    if (obs[7:2] !== 6'b0) begin
      n_fail++;
      $display("FAIL single_arb: got %b required busy/winc/ack all 0", obs);
    end
    cycle();
    for (int k = 0; k < 6; k++) begin
      obs = st();
      n_chk++;
      if (obs !== beat_st(0)) begin
        n_fail++;
        $display("FAIL single_beat%0d: got %b required %b", k, obs, beat_st(0));
      end
      cycle();
    end
    obs = st();
    n_chk++;
    if (obs !== stall_st(0)) begin
      n_fail++;
      $display("FAIL single_release: got %b required %b", obs, stall_st(0));
    end
    cycle();
    obs = st();
    n_chk++;
    if (obs[7:2] !== 6'b0) begin
      n_fail++;
      $display("FAIL single_idle: got %b required idle", obs);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] obs;
    int g;
    do_reset();
    for (int i = 0; i < n_req; i++) set_src(i, i << 6, -1);
    for (int b = 0; b < 20; b++) begin
      g = (b / 4) % 4;
      push_exp(g, (g << 6) + ((b >= 16) ? 4 + (b % 4) : (b % 4)));
    end
    drive();
    #1;
    obs = st();
    n_chk++;
    if (obs[7:2] !== 6'b0) begin
      n_fail++;
      $display("FAIL rr_arb: got %b required idle", obs);
    end
    cycle();
    for (int b = 0; b < 20; b++) begin
      g = (b / 4) % 4;
      obs = st();
      n_chk++;
      if (obs !== beat_st(g)) begin
        n_fail++;
        $display("FAIL rr_beat%0d: got %b required %b", b, obs, beat_st(g));
      end
      if (b == 19) en = '0;
      cycle();
    end
    obs = st();
    n_chk++;
    if (obs !== stall_st(1)) begin
      n_fail++;
      $display("FAIL rr_release: got %b required %b", obs, stall_st(1));
    end
    cycle();
  endtask

  task automatic test_full_stall();
    logic [7:0] obs;
    do_reset();
    set_src(2, 'h20, -1);
    set_src(3, 'h30, -1);
    for (int d = 0; d < 4; d++) push_exp(2, 'h20 + d);
    push_exp(3, 'h30);
    drive();
    #1;
    cycle();
    for (int k = 0; k < 2; k++) begin
      obs = st();
      n_chk++;
      if (obs !== beat_st(2)) begin
        n_fail++;
        $display("FAIL stall_pre%0d: got %b required %b", k, obs, beat_st(2));
      end
      if (k == 1) full_drv = 1'b1;
      cycle();
    end
    for (int k = 0; k < 5; k++) begin
      obs = st();
      n_chk++;
      if (obs !== stall_st(2)) begin
        n_fail++;
        $display("FAIL stall_full%0d: got %b required %b", k, obs, stall_st(2));
      end
      if (k == 4) full_drv = 1'b0;
      cycle();
    end
    for (int k = 0; k < 2; k++) begin
      obs = st();
      n_chk++;
      if (obs !== beat_st(2)) begin
        n_fail++;
        $display("FAIL stall_post%0d: got %b required %b", k, obs, beat_st(2));
      end
      cycle();
    end
    obs = st();
    n_chk++;
    if (obs !== beat_st(3)) begin
      n_fail++;
      $display("FAIL stall_rotate: got %b required %b", obs, beat_st(3));
    end
    en = '0;
    cycle();
    obs = st();
    n_chk++;
    if (obs !== stall_st(3)) begin
      n_fail++;
      $display("FAIL stall_release: got %b required %b", obs, stall_st(3));
    end
    cycle();
  endtask

  task automatic test_release();
    logic [7:0] obs;
    logic [7:0] want[5];
    // Owner 1 leaves after one beat; only requester 3 remains.
    do_reset();
    set_src(1, 'h51, 1);
    set_src(3, 'h70, -1);
    push_exp(1, 'h51);
    push_exp(3, 'h70);
    drive();
    #1;
    cycle();
    want[0] = beat_st(1);
    want[1] = stall_st(1);
    want[2] = beat_st(3);
    for (int k = 0; k < 3; k++) begin
      obs = st();
      n_chk++;
      if (obs !== want[k]) begin
        n_fail++;
        $display("FAIL release_a%0d: got %b required %b", k, obs, want[k]);
      end
      if (k == 2) en = '0;
      cycle();
    end
    cycle();
    // Same, with requester 2 also waiting: it follows owner 1 first.
    do_reset();
    set_src(1, 'h52, 1);
    set_src(2, 'h60, 1);
    set_src(3, 'h71, -1);
    push_exp(1, 'h52);
    push_exp(2, 'h60);
    push_exp(3, 'h71);
    drive();
    #1;
    cycle();
    want[0] = beat_st(1);
    want[1] = stall_st(1);
    want[2] = beat_st(2);
    want[3] = stall_st(2);
    want[4] = beat_st(3);
    for (int k = 0; k < 5; k++) begin
      obs = st();
      n_chk++;
      if (obs !== want[k]) begin
        n_fail++;
        $display("FAIL release_b%0d: got %b required %b", k, obs, want[k]);
      end
      if (k == 4) en = '0;
      cycle();
    end
    cycle();
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] obs;
    do_reset();
    set_src(0, 'h80, -1);
    set_src(1, 'h90, -1);
    push_exp(0, 'h80);
    push_exp(0, 'h81);
    push_exp(0, 'h82);
    drive();
    #1;
    cycle();
    repeat (2) cycle();
    // Third beat of owner 0 is on the port now; reset kills it mid-cycle.
    #1;
    rst = 1'b1;
    #1;
    obs = st();
    n_chk++;
    if (obs[7:2] !== 6'b0) begin
      n_fail++;
      $display("FAIL rstmid_immediate: got %b required busy/winc/ack all 0", obs);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply();
    #1;
    obs = st();
    n_chk++;
    if (obs[7:2] !== 6'b0) begin
      n_fail++;
      $display("FAIL rstmid_arb: got %b required idle", obs);
    end
    cycle();
    obs = st();
    n_chk++;
    if (obs !== beat_st(0)) begin
      n_fail++;
      $display("FAIL rstmid_restart: got %b required %b", obs, beat_st(0));
    end
    en = '0;
    cycle();
    cycle();
  endtask

  task automatic test_full_at_grant();
    logic [7:0] obs;
    do_reset();
    full_drv = 1'b1;
    set_src(2, 'hA0, 3);
    for (int d = 0; d < 3; d++) push_exp(2, 'hA0 + d);
    drive();
    #1;
    cycle();
    for (int k = 0; k < 3; k++) begin
      obs = st();
      n_chk++;
      if (obs !== stall_st(2)) begin
        n_fail++;
        $display("FAIL fullgrant_stall%0d: got %b required %b", k, obs, stall_st(2));
      end
      if (k == 2) full_drv = 1'b0;
      cycle();
    end
    for (int k = 0; k < 3; k++) begin
      obs = st();
      n_chk++;
      if (obs !== beat_st(2)) begin
        n_fail++;
        $display("FAIL fullgrant_beat%0d: got %b required %b", k, obs, beat_st(2));
      end
      cycle();
    end
    obs = st();
    n_chk++;
    if (obs !== stall_st(2)) begin
      n_fail++;
      $display("FAIL fullgrant_release: got %b required %b", obs, stall_st(2));
    end
    cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_release();
    test_reset_mid_burst();
    test_full_at_grant();
    repeat (2) cycle();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d writes missing, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
